// File: rtl/conv_pkg.sv
// conv_pkg: shared constants, FSM state type and helpers for the
// convolution window feeder (conv_window_feeder, conv_row_shift).
//   ROW_W    bits per image row
//   FILT_W   bits per filter row
//   WIN_ROWS image rows per window
//   K_ROWS   filter rows; also new rows needed per subsequent window
package conv_pkg;

  localparam int unsigned ROW_W    = 10;
  localparam int unsigned FILT_W   = 6;
  localparam int unsigned WIN_ROWS = 5;
  localparam int unsigned K_ROWS   = 3;

  typedef enum logic [1:0] {
    IDLE,
    FILT,
    FILL,
    ISSUE
  } state_t;

  // 3-bit counter increment that sticks at 7
  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

endpackage

// File: rtl/conv_row_shift.sv
// conv_row_shift: WIN_ROWS-deep image row register for the window feeder.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (clears all rows)
//   wr_en        write wr_data into row wr_idx
//   wr_idx       target row (0 = oldest)
//   wr_data      row payload
//   zero_above   together with wr_en, clear every row above wr_idx
//   slide        move the top KEEP_ROWS rows down to rows 0..KEEP_ROWS-1
//   rows         packed window, row k at [ROW_W*k +: ROW_W]
module conv_row_shift #(
  parameter int unsigned ROW_W     = conv_pkg::ROW_W,
  parameter int unsigned WIN_ROWS  = conv_pkg::WIN_ROWS,
  parameter int unsigned KEEP_ROWS = conv_pkg::WIN_ROWS - conv_pkg::K_ROWS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [2:0]                wr_idx,
  input  logic [ROW_W-1:0]          wr_data,
  input  logic                      zero_above,
  input  logic                      slide,
  output logic [WIN_ROWS*ROW_W-1:0] rows
);

  logic [ROW_W-1:0] r [WIN_ROWS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < WIN_ROWS; k++) r[k] <= '0;
    end else if (slide) begin
      // Rows above the retained overlap are cleared; they are always
      // rewritten before the next window issues.
      for (int unsigned k = 0; k < WIN_ROWS; k++) begin
        if (k < KEEP_ROWS) r[k] <= r[(k + WIN_ROWS - KEEP_ROWS) % WIN_ROWS];
        else               r[k] <= '0;
      end
    end else if (wr_en) begin
      for (int unsigned k = 0; k < WIN_ROWS; k++) begin
        if (wr_idx == 3'(k))                    r[k] <= wr_data;
        else if (zero_above && (3'(k) > wr_idx)) r[k] <= '0;
      end
    end
  end

  always_comb begin
    rows = '0;
    for (int unsigned k = 0; k < WIN_ROWS; k++) rows[ROW_W*k +: ROW_W] = r[k];
  end

endmodule

// File: rtl/conv_window_feeder.sv
// conv_window_feeder: assembles 3-row filters and 5-row image windows from a
// valid/ready row stream and hands windows to the PE array.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   s_valid/s_ready       input row handshake (s_ready is a decode of state)
//   s_data                row payload (filter rows use the low FILT_W bits)
//   s_is_filter, s_last   beat is a filter row / last image row of frame
//   m_valid/m_ready       window handshake
//   pe_in, pe_filter      window rows and filter rows (row 0 at LSBs)
//   win_cnt               windows handed off, 8-bit wrapping
//   err                   sticky protocol error (wrong beat type)
// Build option: CONV_WINDOW_FEEDER_ZPAD_EN zero-pads and issues a window cut
// short by s_last; otherwise such a window is discarded.
module conv_window_feeder #(
  parameter int unsigned ROW_W    = conv_pkg::ROW_W,
  parameter int unsigned FILT_W   = conv_pkg::FILT_W,
  parameter int unsigned WIN_ROWS = conv_pkg::WIN_ROWS,
  parameter int unsigned K_ROWS   = conv_pkg::K_ROWS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [ROW_W-1:0]          s_data,
  input  logic                      s_is_filter,
  input  logic                      s_last,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [WIN_ROWS*ROW_W-1:0] pe_in,
  output logic [K_ROWS*FILT_W-1:0]  pe_filter,
  output logic [7:0]                win_cnt,
  output logic                      err
);
  import conv_pkg::*;

  localparam int unsigned KEEP = WIN_ROWS - K_ROWS;

`ifdef CONV_WINDOW_FEEDER_ZPAD_EN
  localparam logic   ZPAD        = 1'b1;
  localparam state_t TRUNC_STATE = ISSUE;
`else
  localparam logic   ZPAD        = 1'b0;
  localparam state_t TRUNC_STATE = IDLE;
`endif

  state_t           state, state_n;
  logic [2:0]       cnt, cnt_n, fcnt, fcnt_n;
  logic             frame_end, frame_end_n;
  logic [FILT_W-1:0] filt [K_ROWS];

  logic             acc, last_row;
  logic [2:0]       wr_idx, filt_idx;
  logic             wr_en, zero_above, slide, filt_we, err_set, win_inc;

  assign acc      = s_valid && s_ready;
  // IDLE always restarts at row 0 regardless of any stale count
  assign wr_idx   = (state == IDLE) ? '0 : cnt;
  assign filt_idx = (state == IDLE) ? '0 : fcnt;
  assign last_row = (wr_idx == 3'(WIN_ROWS - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:
        if (acc) begin
          if (s_is_filter) state_n = FILT;
          else if (s_last) state_n = TRUNC_STATE;
          else             state_n = FILL;
        end
      FILT:
        if (acc && s_is_filter && (fcnt == 3'(K_ROWS - 1))) state_n = FILL;
      FILL:
        if (acc && !s_is_filter) begin
          if (last_row)    state_n = ISSUE;
          else if (s_last) state_n = TRUNC_STATE;
        end
      ISSUE:
        if (m_ready) state_n = frame_end ? IDLE : FILL;
      default: state_n = IDLE;
    endcase
  end

  // Output / datapath control decode
  always_comb begin
    s_ready     = rst_n && (state != ISSUE);
    cnt_n       = cnt;
    fcnt_n      = fcnt;
    frame_end_n = frame_end;
    wr_en       = 1'b0;
    zero_above  = 1'b0;
    slide       = 1'b0;
    filt_we     = 1'b0;
    err_set     = 1'b0;
    win_inc     = 1'b0;
    case (state)
      IDLE:
        if (acc) begin
          if (s_is_filter) begin
            filt_we     = 1'b1;
            fcnt_n      = 3'd1;
            frame_end_n = 1'b0;
          end else begin
            wr_en       = 1'b1;
            cnt_n       = 3'd1;
            frame_end_n = s_last;
            zero_above  = ZPAD && s_last;
          end
        end
      FILT:
        if (acc) begin
          if (s_is_filter) begin
            filt_we = 1'b1;
            fcnt_n  = sat_inc3(fcnt);
            if (fcnt == 3'(K_ROWS - 1)) cnt_n = '0;
          end else begin
            err_set = 1'b1;
          end
        end
      FILL:
        if (acc) begin
          if (s_is_filter) begin
            err_set = 1'b1;
          end else begin
            wr_en       = 1'b1;
            cnt_n       = sat_inc3(cnt);
            frame_end_n = s_last;
            zero_above  = ZPAD && s_last;
          end
        end
      ISSUE:
        if (m_ready) begin
          win_inc     = 1'b1;
          frame_end_n = 1'b0;
          if (!frame_end) begin
            slide = 1'b1;
            cnt_n = 3'(KEEP);
          end
        end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      fcnt      <= '0;
      frame_end <= 1'b0;
      m_valid   <= 1'b0;
      win_cnt   <= '0;
      err       <= 1'b0;
      for (int unsigned j = 0; j < K_ROWS; j++) filt[j] <= '0;
    end else begin
      cnt       <= cnt_n;
      fcnt      <= fcnt_n;
      frame_end <= frame_end_n;
      m_valid   <= (state_n == ISSUE);
      if (win_inc) win_cnt <= win_cnt + 8'd1;
      if (err_set) err <= 1'b1;
      for (int unsigned j = 0; j < K_ROWS; j++)
        if (filt_we && (filt_idx == 3'(j))) filt[j] <= s_data[FILT_W-1:0];
    end
  end

  always_comb begin
    pe_filter = '0;
    for (int unsigned j = 0; j < K_ROWS; j++) pe_filter[FILT_W*j +: FILT_W] = filt[j];
  end

  conv_row_shift #(
    .ROW_W    (ROW_W),
    .WIN_ROWS (WIN_ROWS),
    .KEEP_ROWS(KEEP)
  ) u_rows (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_data   (s_data),
    .zero_above(zero_above),
    .slide     (slide),
    .rows      (pe_in)
  );

endmodule

// File: doc/conv_window_feeder.md
# conv_window_feeder

Streaming front end for the 3x3 convolution PE array. It accepts filter rows and image rows one beat at a time over a valid/ready stream. It assembles the 5-row input window and 3-row filter that the array consumes, and presents each window with a valid/ready handshake. Between windows it keeps the two overlapping rows, so each subsequent window needs only 3 new rows.

## Interface
Parameters:
- ROW_W, 10, bits per image row (one PE input slice)
- FILT_W, 6, bits per filter row
- WIN_ROWS, 5, image rows per window
- K_ROWS, 3, filter rows; also the number of new rows per subsequent window

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid && s_ready
- s_data  in  ROW_W  row payload; filter beats use s_data[FILT_W-1:0]
- s_is_filter  in  1  beat is a filter row
- s_last  in  1  beat is the last image row of the frame
- m_valid  out  1  window valid
- m_ready  in  1  downstream accepts the window
- pe_in  out  WIN_ROWS*ROW_W  window; row k (k=0 oldest) at [ROW_W*k +: ROW_W]
- pe_filter  out  K_ROWS*FILT_W  filter; row j at [FILT_W*j +: FILT_W]
- win_cnt  out  8  windows handed off, wraps 255->0
- err  out  1  sticky protocol error

## Operation
- States: IDLE, FILT, FILL, ISSUE.
- s_ready is 1 in IDLE, FILT and FILL. It is 0 in ISSUE and while rst_n is low.
- IDLE:
  - Accepted filter beat: stored as filter row 0; go to FILT.
  - Accepted image beat: stored as window row 0; go to FILL. The current filter is reused.
- FILT:
  - Filter beats fill rows 1 and 2; after row 2, go to FILL with row count 0.
  - An accepted beat with s_is_filter=0 is dropped and sets err. The filter row count does not advance.
  - s_last is ignored.
- FILL:
  - Image beats are written to the next free window row.
  - An accepted filter beat is dropped and sets err.
  - When row 4 is written, go to ISSUE.
- ISSUE:
  - m_valid=1; pe_in and pe_filter are held stable until m_ready.
  - On handshake, win_cnt increments.
  - If the frame has ended, go to IDLE. Otherwise shift rows 3,4 into rows 0,1 and go to FILL with row count 2.
- s_last on an image beat marks frame end. If that beat completes the window, the window issues normally and then the block returns to IDLE.
- Incomplete window at s_last: behaviour is set by the macro (see Configuration).
- pe_filter persists across frames; only filter beats change it.
- Widths: no arithmetic on data; counts are 3-bit saturating within the window.

## Timing
- Reset values:
  - outputs: m_valid=0, pe_in=0, pe_filter=0, win_cnt=0, err=0
  - state IDLE, row count 0
- Latency: the beat that completes the window is accepted at edge N; m_valid is 1 from edge N through the handshake edge.
- After the handshake edge, s_ready is 1 in the next cycle. Minimum spacing between windows is 4 cycles (1 ISSUE cycle + 3 row beats).
- m_valid and the outputs are registered; s_ready is a combinational decode of state.
- rst_n asserted mid-window: everything returns to reset values immediately. A partial window and the filter are lost.

## Configuration
- CONV_WINDOW_FEEDER_ZPAD_EN defined:
  - s_last on an incomplete window zero-fills the remaining rows and goes to ISSUE the next cycle.
  - After the handshake, the block returns to IDLE.
- Not defined:
  - The incomplete window is discarded with no m_valid, and the block returns to IDLE.
  - win_cnt is unchanged.

## Structure
- Package conv_pkg holds:
  - ROW_W, FILT_W, WIN_ROWS, K_ROWS constants
  - the state enum (IDLE, FILT, FILL, ISSUE)
- One sub-module, conv_row_shift, holds the 5-row window register with row write enable, 2-row slide, and zero-fill.

## Test plan
- Reset: drive rst_n low during ISSUE -> m_valid=0, s_ready=0, win_cnt=0, err=0. After release, s_ready=1 in IDLE.
- Filter load: beats 6'h01, 6'h02, 6'h03 with s_is_filter=1 -> pe_filter=18'h03081.
- Window and slide:
  - rows 10'h001..10'h005, m_ready=1 -> m_valid the cycle after row 5; pe_in={005,004,003,002,001}; win_cnt=1.
  - rows 006..008 -> pe_in={008,007,006,005,004}; win_cnt=2.
- Backpressure: m_ready=0 for 4 cycles -> pe_in stable, s_ready=0; handshake on cycle 5 only.
- Frame end: s_last on row 007 after 2 of 3 new rows.
  - With ZPAD_EN: pe_in={000,007,006,005,004}, then IDLE.
  - Without: no m_valid, IDLE, win_cnt unchanged.
- Protocol error: image beat during FILT -> err=1, beat dropped, 3 filter beats still required before FILL.
